// File: rtl/stream_cipher_rx.sv
// Receive-side (decrypt) datapath of the stream cipher.
// Each accepted ciphertext byte is XORed with one keystream byte taken from a
// keyed Galois LFSR (right-shift form). Plaintext leaves through a single
// output register with valid/ready handshaking. After every key load the
// first WARMUP keystream bytes are discarded so both ends stay aligned.
module stream_cipher_rx #(
   parameter logic [31:0] POLY   = 32'hD000_0001,
   parameter int unsigned WARMUP = 4
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        key_load,
   input  logic [31:0] key,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        keyed,
   output logic [15:0] byte_cnt
);

   // Last warm-up step index; only meaningful when WARMUP is non-zero.
   localparam logic [7:0] WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WARM = 2'd1,
      RUN  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] lfsr_q, lfsr_d;
   logic [7:0]  warm_cnt_q, warm_cnt_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  out_data_q, out_data_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;

   logic        keyed_s;
   logic        in_ready_s;
   logic        accept_s;
   logic [39:0] step_s;
   logic [31:0] lfsr_step_s;
   logic [7:0]  ks_s;
   logic [31:0] seed_s;

   // Eight Galois shifts in one go: returns {next_state, keystream_byte},
   // first bit shifted out lands in keystream bit 0.
   function automatic logic [39:0] byte_step(input logic [31:0] s_in);
      logic [31:0] s;
      logic [7:0]  k;
      s = s_in;
      k = 8'h00;
      for (int i = 0; i < 8; i++) begin
         k[i] = s[0];
         s    = {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0000_0000);
      end
      return {s, k};
   endfunction

   assign step_s      = byte_step(lfsr_q);
   assign lfsr_step_s = step_s[39:8];
   assign ks_s        = step_s[7:0];

   // An all-zero seed would lock the LFSR, so it is promoted to 1.
   assign seed_s   = (key == 32'h0000_0000) ? 32'h0000_0001 : key;
   assign accept_s = in_valid && in_ready_s;

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: key_load overrides everything, warm-up counts down to RUN.
   always_comb begin
      state_d = state_q;
      if (key_load) begin
         if (WARMUP == 0) begin
            state_d = RUN;
         end else begin
            state_d = WARM;
         end
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            WARM: begin
               if (warm_cnt_q == WARM_LAST) begin
                  state_d = RUN;
               end else begin
                  state_d = WARM;
               end
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs: keyed flag and the combinational input-ready.
   always_comb begin
      keyed_s    = 1'b0;
      in_ready_s = 1'b0;
      case (state_q)
         RUN: begin
            keyed_s    = 1'b1;
            in_ready_s = !key_load && (!out_valid_q || out_ready);
         end
         IDLE, WARM: begin
            keyed_s    = 1'b0;
            in_ready_s = 1'b0;
         end
         default: begin
            keyed_s    = 1'b0;
            in_ready_s = 1'b0;
         end
      endcase
   end

   // Datapath next-state: LFSR only moves on key load, warm-up or an accept.
   always_comb begin
      lfsr_d      = lfsr_q;
      warm_cnt_d  = warm_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      byte_cnt_d  = byte_cnt_q;
      if (key_load) begin
         lfsr_d      = seed_s;
         warm_cnt_d  = 8'd0;
         out_valid_d = 1'b0;
         byte_cnt_d  = 16'd0;
      end else if (state_q == WARM) begin
         lfsr_d     = lfsr_step_s;
         warm_cnt_d = warm_cnt_q + 8'd1;
         if (out_ready) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
         end
      end else if (accept_s) begin
         lfsr_d      = lfsr_step_s;
         out_data_d  = in_data ^ ks_s;
         out_valid_d = 1'b1;
         byte_cnt_d  = byte_cnt_q + 16'd1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         lfsr_q      <= 32'h0000_0000;
         warm_cnt_q  <= 8'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         byte_cnt_q  <= 16'd0;
      end else begin
         lfsr_q      <= lfsr_d;
         warm_cnt_q  <= warm_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         byte_cnt_q  <= byte_cnt_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign keyed     = keyed_s;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign byte_cnt  = byte_cnt_q;

endmodule
